// File: rtl/apple_shadow_pkg.sv
// apple_shadow_pkg: shared FSM state type and byte-lane constant for the shadow bank.
// Contents: state_t (CLEAR, RUN) and BE_W, the number of byte lanes per RAM word.
package apple_shadow_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int BE_W = 4;
endpackage

// File: rtl/apple_shadow_fifo.sv
// apple_shadow_fifo: write-snoop queue with occupancy level, push+pop legal at any level.
// Ports: clk_logic/system_reset clock and async reset; push_i/din_i enqueue;
// pop_i dequeue; dout_o head entry; level_o occupancy; full_o/empty_o status.
module apple_shadow_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_logic,
    input  logic                     system_reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic do_push, do_pop;
    assign full_o  = level_o == (PW+1)'(DEPTH);
    assign empty_o = level_o == '0;
    assign do_pop  = pop_i && !empty_o;
    // a full queue still takes a push when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = buf_q[rp_q];
    always_ff @(posedge clk_logic)
        if (do_push) buf_q[wp_q] <= din_i;
    always_ff @(posedge clk_logic or posedge system_reset)
        if (system_reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_o <= '0;
        end else begin
            wp_q    <= wp_q + PW'(do_push);
            rp_q    <= rp_q + PW'(do_pop);
            level_o <= level_o + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
endmodule

// File: rtl/apple_shadow_bank.sv
// apple_shadow_bank: single-port shadow RAM fed by a byte-write snoop queue and read by
// round-robin video channels, with a word-by-word clear sequence.
// Ports: clk_logic/system_reset clock and async reset; clear_i starts a clear;
// wr_valid_i/wr_addr_i/wr_data_i byte write snoop, wr_ready_o, overflow_o sticky drop flag;
// rd_req_i/rd_addr_i per-channel reads, rd_ack_o grant, rd_valid_o/rd_data_o response;
// busy_o high while clearing.
module apple_shadow_bank
    import apple_shadow_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_PORTS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int HIGH_WATER = 2
) (
    input  logic                            clk_logic,
    input  logic                            system_reset,
    input  logic                            clear_i,
    input  logic                            wr_valid_i,
    input  logic [ADDR_WIDTH+1:0]           wr_addr_i,
    input  logic [7:0]                      wr_data_i,
    output logic                            wr_ready_o,
    output logic                            overflow_o,
    input  logic [NUM_PORTS-1:0]            rd_req_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_PORTS-1:0]            rd_ack_o,
    output logic [NUM_PORTS-1:0]            rd_valid_o,
    output logic [31:0]                     rd_data_o,
    output logic                            busy_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + 10;
    state_t state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [1:0] ptr_q;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [EW-1:0] head;
    logic [LW-1:0] level;
    logic [BE_W-1:0] be;
    logic full, empty, run, hi, pop, push, rd_en, found;
    int gidx;
    assign run        = state_q == RUN;
    assign busy_o     = !run;
    assign hi         = int'(level) >= HIGH_WATER;
    assign rd_en      = run && found && !hi;
    assign pop        = run && !empty && (hi || !found);
    assign wr_ready_o = !full || pop;
    assign push       = wr_valid_i && wr_ready_o;
    assign rd_ack_o   = rd_en ? NUM_PORTS'(1) << gidx : '0;
    assign be         = BE_W'(1) << head[9:8];
    // first requester at or after the channel following the last grant
    always_comb begin
        found = 1'b0;
        gidx  = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rd_req_i[(int'(ptr_q) + i) % NUM_PORTS]) begin
                found = 1'b1;
                gidx  = (int'(ptr_q) + i) % NUM_PORTS;
            end
        end
    end
    // queue entry layout: {word address, byte lane, byte}
    apple_shadow_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
        .clk_logic   (clk_logic),
        .system_reset(system_reset),
        .push_i      (push),
        .din_i       ({wr_addr_i, wr_data_i}),
        .pop_i       (pop),
        .dout_o      (head),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );
    // one RAM access per cycle: clear write, queue pop, or (below) the granted read
    always_ff @(posedge clk_logic)
        if (!run) mem[cnt_q] <= '0;
        else if (pop)
            for (int b = 0; b < BE_W; b++)
                if (be[b]) mem[head[EW-1:10]][8*b +: 8] <= head[7:0];
    always_ff @(posedge clk_logic or posedge system_reset)
        if (system_reset) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            ptr_q      <= '0;
            overflow_o <= 1'b0;
            rd_valid_o <= '0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_ack_o;
            if (rd_en) begin
                rd_data_o <= mem[rd_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH]];
                ptr_q     <= 2'((gidx + 1) % NUM_PORTS);
            end
            overflow_o <= !clear_i && (overflow_o || (wr_valid_i && !wr_ready_o));
            if (clear_i) begin
                state_q <= CLEAR;
                cnt_q   <= '0;
            end else if (!run) begin
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q) state_q <= RUN;
            end
        end
endmodule

// File: tb/tb_apple_shadow_bank.sv
// tb_apple_shadow_bank: randomized and directed checks of apple_shadow_bank against a queue/array reference model.
module tb_apple_shadow_bank;
    localparam int AW = 4, NP = 2, DEPTH = 4, HW = 2, NW = 16;
    logic clk = 0, rst = 1, clear = 0, wr_valid = 0;
    logic [AW+1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [NP-1:0] rd_req = '0;
    logic [NP*AW-1:0] rd_addr = '0;
    logic wr_ready_o, overflow_o, busy_o;
    logic [NP-1:0] rd_ack_o, rd_valid_o;
    logic [31:0] rd_data_o;
    int checks = 0, failures = 0;

    apple_shadow_bank #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .HIGH_WATER(HW)) dut (
        .clk_logic(clk), .system_reset(rst), .clear_i(clear),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready_o), .overflow_o(overflow_o),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // reference model: RAM image, pending-write queue, clear progress, arbitration pointer
    logic [31:0] m_mem [NW];
    logic [AW+9:0] m_q [$];
    bit m_run, m_ovf, e_ready, e_pop;
    int m_cnt, m_ptr, e_g;
    logic [NP-1:0] m_valid, e_ack;
    logic [31:0] m_data;

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_ovf = 0; m_ptr = 0;
        m_q.delete(); m_valid = '0; m_data = '0;
    endtask

    // settle the inputs driven this cycle and predict this cycle's decisions
    task automatic settle();
        bit hi;
        #1;
        hi = m_q.size() >= HW;
        e_ack = '0; e_g = -1;
        if (m_run && !hi)
            for (int i = 0; i < NP; i++)
                if (e_g < 0 && rd_req[(m_ptr + i) % NP]) e_g = (m_ptr + i) % NP;
        if (e_g >= 0) e_ack[e_g] = 1'b1;
        e_pop = m_run && m_q.size() > 0 && (hi || rd_req == '0);
        e_ready = m_q.size() < DEPTH || e_pop;
    endtask

    // apply this cycle's effects to the model and clock the DUT
    task automatic advance();
        logic [AW+9:0] e;
        if (e_g >= 0) begin
            m_data = m_mem[rd_addr[e_g*AW +: AW]];
            m_ptr = (e_g + 1) % NP;
        end
        m_valid = e_ack;
        if (e_pop) begin
            e = m_q.pop_front();
            m_mem[e[AW+9:10]][int'(e[9:8])*8 +: 8] = e[7:0];
        end
        if (!m_run) begin
            m_mem[m_cnt] = '0;
            if (clear) m_cnt = 0;
            else if (m_cnt == NW - 1) begin m_run = 1; m_cnt = 0; end
            else m_cnt++;
        end else if (clear) begin
            m_run = 0; m_cnt = 0;
        end
        if (wr_valid && e_ready) m_q.push_back({wr_addr, wr_data});
        m_ovf = clear ? 1'b0 : (m_ovf || (wr_valid && !e_ready));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin settle(); advance(); end
    endtask

    task automatic do_write(input logic [AW+1:0] a, input logic [7:0] d);
        wr_valid = 1; wr_addr = a; wr_data = d;
        settle(); advance();
        wr_valid = 0;
    endtask

    task automatic do_read(input int ch, input logic [AW-1:0] a, output logic [31:0] d, output logic [NP-1:0] v);
        bit got = 0;
        rd_req = NP'(1) << ch;
        rd_addr[ch*AW +: AW] = a;
        for (int i = 0; i < 20 && !got; i++) begin
            settle();
            got = rd_ack_o[ch];
            advance();
        end
        rd_req = '0;
        d = got ? rd_data_o : 32'hx;
        v = rd_valid_o;
    endtask

    task automatic test_reset();
        int n = 0;
        logic [31:0] d;
        logic [NP-1:0] v;
        rst = 1; rd_req = '1;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({busy_o, wr_ready_o, overflow_o} !== 3'b110) begin
            failures++;
            $display("FAIL reset_flags busy/ready/ovf got %b want 110", {busy_o, wr_ready_o, overflow_o});
        end
        checks++;
        if ({rd_ack_o, rd_valid_o} !== '0) begin
            failures++;
            $display("FAIL reset_rd ack/valid got %b want 0", {rd_ack_o, rd_valid_o});
        end
        checks++;
        if (rd_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got %h want 00000000", rd_data_o);
        end
        rst = 0; rd_req = '0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (!busy_o) break;
            n++;
            advance();
        end
        checks++;
        if (n != NW) begin
            failures++;
            $display("FAIL reset_busy_cycles got %0d want %0d", n, NW);
        end
        for (int w = 0; w < NW; w++) begin
            do_read(w % NP, AW'(w), d, v);
            checks++;
            if (d !== 32'h0 || v !== NP'(1) << (w % NP)) begin
                failures++;
                $display("FAIL cleared_word %0d got %h/%b want 00000000/%b", w, d, v, NP'(1) << (w % NP));
            end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] d;
        logic [NP-1:0] v;
        do_write(6'd6, 8'hA5);
        idle(2);
        do_read(0, 4'd1, d, v);
        checks++;
        if (d !== 32'h00A50000) begin
            failures++;
            $display("FAIL byte_lane2 got %h want 00a50000", d);
        end
        for (int i = 0; i < 8; i++) begin
            do_write(6'($urandom), 8'($urandom));
            idle(int'($urandom_range(0, 2)));
            do_read(int'($urandom_range(0, NP - 1)), 4'($urandom), d, v);
            checks++;
            if (d !== m_data) begin
                failures++;
                $display("FAIL random_byte_write got %h want %h", d, m_data);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] d;
        logic [NP-1:0] v, exp;
        idle(4);
        do_read(1, 4'd0, d, v);
        rd_req = 2'b11;
        rd_addr = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            checks++;
            if (rd_ack_o !== exp) begin
                failures++;
                $display("FAIL rr_ack cycle %0d got %b want %b", i, rd_ack_o, exp);
            end
            advance();
            checks++;
            if (rd_valid_o !== exp || rd_data_o !== m_data) begin
                failures++;
                $display("FAIL rr_valid cycle %0d got %b/%h want %b/%h", i, rd_valid_o, rd_data_o, exp, m_data);
            end
        end
        rd_req = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [NP-1:0] v, exp;
        idle(4);
        rd_req = 2'b01;
        rd_addr[AW-1:0] = 4'd3;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1;
            wr_addr = {4'd2, 2'(i % 4)};
            wr_data = 8'($urandom);
            exp = i < 2 ? 2'b01 : 2'b00;
            settle();
            checks++;
            if (rd_ack_o !== exp || wr_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_arb write %0d got ack %b ready %b want %b 1", i, rd_ack_o, wr_ready_o, exp);
            end
            advance();
        end
        wr_valid = 0; rd_req = '0;
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overflow got %b want 0", overflow_o);
        end
        idle(6);
        do_read(0, 4'd2, d, v);
        checks++;
        if (d !== m_data) begin
            failures++;
            $display("FAIL b2b_readback got %h want %h", d, m_data);
        end
    endtask

    task automatic test_clear_overflow();
        logic [31:0] d;
        logic [NP-1:0] v;
        idle(4);
        clear = 1;
        settle(); advance();
        clear = 0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL clear_enter busy got %b want 1", busy_o);
        end
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1;
            wr_addr = i < 4 ? {4'd5, 2'(i)} : {4'd6, 2'd0};
            wr_data = i < 4 ? 8'(8'h11 * (i + 1)) : 8'h55;
            settle();
            checks++;
            if (wr_ready_o !== (i < 4)) begin
                failures++;
                $display("FAIL clear_ready write %0d got %b want %b", i, wr_ready_o, i < 4);
            end
            advance();
        end
        wr_valid = 0;
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL clear_overflow got %b want 1", overflow_o);
        end
        for (int i = 0; i < 40 && busy_o; i++) idle(1);
        idle(6);
        do_read(0, 4'd5, d, v);
        checks++;
        if (d !== 32'h44332211) begin
            failures++;
            $display("FAIL queued_after_clear got %h want 44332211", d);
        end
        do_read(1, 4'd6, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL dropped_write got %h want 00000000", d);
        end
    endtask

    task automatic test_clear_restart();
        int n = 0;
        logic [31:0] d;
        logic [NP-1:0] v;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            wr_valid = i < 5;
            wr_addr = i < 4 ? {4'd9, 2'(i)} : {4'd10, 2'd0};
            wr_data = 8'(8'hA0 + i);
            settle(); advance();
        end
        wr_valid = 0;
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL restart_pre_overflow got %b want 1", overflow_o);
        end
        clear = 1;
        settle(); advance();
        clear = 0;
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL restart_overflow_clr got %b want 0", overflow_o);
        end
        for (int i = 0; i < 40; i++) begin
            settle();
            if (!busy_o) break;
            n++;
            advance();
        end
        checks++;
        if (n != NW) begin
            failures++;
            $display("FAIL restart_busy_cycles got %0d want %0d", n, NW);
        end
        idle(6);
        do_read(0, 4'd9, d, v);
        checks++;
        if (d !== 32'hA3A2A1A0) begin
            failures++;
            $display("FAIL restart_queued got %h want a3a2a1a0", d);
        end
    endtask

    task automatic test_reset_midread();
        idle(4);
        rd_req = 2'b01;
        rd_addr[AW-1:0] = 4'd9;
        settle();
        checks++;
        if (rd_ack_o !== 2'b01) begin
            failures++;
            $display("FAIL midread_ack got %b want 01", rd_ack_o);
        end
        rst = 1;
        #1;
        checks++;
        if (rd_ack_o !== 2'b00 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midread_in_reset ack/busy got %b/%b want 00/1", rd_ack_o, busy_o);
        end
        @(posedge clk); #1;
        rst = 0; rd_req = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            settle(); advance();
            checks++;
            if (rd_valid_o !== '0 || rd_data_o !== 32'h0) begin
                failures++;
                $display("FAIL midread_after_reset cycle %0d got %b/%h want 00/00000000", i, rd_valid_o, rd_data_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rd_req = NP'($urandom);
            rd_addr = (NP*AW)'($urandom);
            wr_valid = 1'($urandom);
            wr_addr = (AW+2)'($urandom);
            wr_data = 8'($urandom);
            clear = $urandom_range(0, 199) == 0;
            settle();
            checks++;
            if ({rd_ack_o, wr_ready_o} !== {e_ack, e_ready}) begin
                failures++;
                $display("FAIL rand_arb cycle %0d ack/ready got %b/%b want %b/%b", i, rd_ack_o, wr_ready_o, e_ack, e_ready);
            end
            advance();
            checks++;
            if ({rd_valid_o, rd_data_o, busy_o, overflow_o} !== {m_valid, m_data, !m_run, m_ovf}) begin
                failures++;
                $display("FAIL rand_out cycle %0d valid/data/busy/ovf got %b/%h/%b/%b want %b/%h/%b/%b",
                         i, rd_valid_o, rd_data_o, busy_o, overflow_o, m_valid, m_data, !m_run, m_ovf);
            end
        end
        rd_req = '0; wr_valid = 0; clear = 0;
    endtask

    initial begin
        for (int w = 0; w < NW; w++) m_mem[w] = 32'hx;
        model_reset();
        test_reset();
        test_byte_write();
        test_round_robin();
        test_back_to_back();
        test_clear_overflow();
        test_clear_restart();
        test_reset_midread();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
